// File: rtl/patch_ctrl_pkg.sv
// rtl/patch_ctrl_pkg.sv - shared mode/state types and lane-frame layout for patch_signal_controller
package patch_ctrl_pkg;

    typedef enum logic [1:0] {
        PASS   = 2'b00,
        FORCE0 = 2'b01,
        FORCE1 = 2'b10,
        INVERT = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } lane_state_e;

    // Lane frame, LSB first: mode, tsel, hold
    localparam int MODE_LSB = 0;
    localparam int MODE_W   = 2;
    localparam int TSEL_LSB = MODE_LSB + MODE_W;

    function automatic int tsel_width(input int num_trig);
        return (num_trig > 1) ? $clog2(num_trig) : 1;
    endfunction

    function automatic int hold_lsb(input int tsel_w);
        return TSEL_LSB + tsel_w;
    endfunction

    function automatic int frame_width(input int tsel_w, input int hold_w);
        return MODE_W + tsel_w + hold_w;
    endfunction

endpackage

// File: rtl/patch_ctrl_lane.sv
// rtl/patch_ctrl_lane.sv - one controlled lane: trigger select, hold counter FSM and override mux
module patch_ctrl_lane
    import patch_ctrl_pkg::*;
#(
    parameter int NUM_TRIG = 4,
    parameter int TSEL_W   = 2,
    parameter int HOLD_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                commit,
    input  logic [1:0]          mode,
    input  logic [TSEL_W-1:0]   tsel,
    input  logic [HOLD_W-1:0]   hold,
    input  logic [NUM_TRIG-1:0] trig_in,
    input  logic                sig_in,
    output logic                sig_out,
    output logic                ovr_active
);

    localparam logic ST_IDLE   = IDLE;
    localparam logic ST_ACTIVE = ACTIVE;
    localparam logic [HOLD_W-1:0] HOLD_STICKY = '1;

    logic              state;
    logic [HOLD_W-1:0] cnt;
    logic              trig_hit;

    // Out-of-range tsel matches no index and leaves trig_hit low
    always_comb begin
        trig_hit = 1'b0;
        for (int k = 0; k < NUM_TRIG; k++) begin
            if (tsel == TSEL_W'(k)) begin
                trig_hit = trig_in[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (commit) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (state == ST_IDLE) begin
            if (mode != PASS && trig_hit) begin
                state <= ST_ACTIVE;
                cnt   <= hold;
            end
        end else if (trig_hit) begin
            cnt <= hold;
        end else if (hold != HOLD_STICKY) begin
            if (cnt != '0) begin
                cnt <= cnt - HOLD_W'(1);
            end else begin
                state <= ST_IDLE;
            end
        end
    end

    always_comb begin
        sig_out = sig_in;
        if (state == ST_ACTIVE) begin
            case (mode)
                FORCE0:  sig_out = 1'b0;
                FORCE1:  sig_out = 1'b1;
                INVERT:  sig_out = ~sig_in;
                default: sig_out = sig_in;
            endcase
        end
    end

    assign ovr_active = (state == ST_ACTIVE);

endmodule

// File: rtl/patch_signal_controller.sv
// rtl/patch_signal_controller.sv - serial-configured trigger-driven signal override; PATCH_CTRL_READBACK_EN enables cfg_dout
module patch_signal_controller
    import patch_ctrl_pkg::*;
#(
    parameter int NUM_SIG  = 4,
    parameter int NUM_TRIG = 4,
    parameter int HOLD_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_TRIG-1:0] trig_in,
    input  logic [NUM_SIG-1:0]  sig_in,
    output logic [NUM_SIG-1:0]  sig_out,
    input  logic                cfg_shift,
    input  logic                cfg_bit,
    input  logic                cfg_commit,
    output logic                cfg_dout,
    output logic [NUM_SIG-1:0]  ovr_active
);

    localparam int TSEL_W   = tsel_width(NUM_TRIG);
    localparam int FW       = frame_width(TSEL_W, HOLD_W);
    localparam int HOLD_LSB = hold_lsb(TSEL_W);
    localparam int CFG_W    = NUM_SIG * FW;

    logic [CFG_W-1:0] shadow;
    logic [CFG_W-1:0] active_cfg;

    // Commit samples shadow before this edge's shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow     <= '0;
            active_cfg <= '0;
        end else begin
            if (cfg_shift) begin
                shadow <= {cfg_bit, shadow[CFG_W-1:1]};
            end
            if (cfg_commit) begin
                active_cfg <= shadow;
            end
        end
    end

`ifdef PATCH_CTRL_READBACK_EN
    logic dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= 1'b0;
        end else if (cfg_shift) begin
            dout_q <= shadow[0];
        end
    end

    assign cfg_dout = dout_q;
`else
    assign cfg_dout = 1'b0;
`endif

    for (genvar i = 0; i < NUM_SIG; i++) begin : g_lane
        logic [FW-1:0] frame;
        assign frame = active_cfg[i*FW +: FW];

        patch_ctrl_lane #(
            .NUM_TRIG (NUM_TRIG),
            .TSEL_W   (TSEL_W),
            .HOLD_W   (HOLD_W)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .commit     (cfg_commit),
            .mode       (frame[MODE_LSB +: MODE_W]),
            .tsel       (frame[TSEL_LSB +: TSEL_W]),
            .hold       (frame[HOLD_LSB +: HOLD_W]),
            .trig_in    (trig_in),
            .sig_in     (sig_in[i]),
            .sig_out    (sig_out[i]),
            .ovr_active (ovr_active[i])
        );
    end

endmodule

// File: tb/tb_patch_signal_controller.sv
// tb/tb_patch_signal_controller.sv - scoreboard bench for patch_signal_controller against a remaining-cycles model
module tb_patch_signal_controller;

    localparam int NS = 4;
    localparam int NT = 4;
    localparam int HW = 8;
    localparam int TW = 2;
    localparam int FW = 2 + TW + HW;
    localparam int CW = NS * FW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NT-1:0] trig_in = '0;
    logic [NS-1:0] sig_in = 4'b1010;
    logic          cfg_shift = 1'b0;
    logic          cfg_bit = 1'b0;
    logic          cfg_commit = 1'b0;
    logic [NS-1:0] sig_out;
    logic [NS-1:0] ovr_active;
    logic          cfg_dout;

    patch_signal_controller #(.NUM_SIG(NS), .NUM_TRIG(NT), .HOLD_W(HW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trig_in    (trig_in),
        .sig_in     (sig_in),
        .sig_out    (sig_out),
        .cfg_shift  (cfg_shift),
        .cfg_bit    (cfg_bit),
        .cfg_commit (cfg_commit),
        .cfg_dout   (cfg_dout),
        .ovr_active (ovr_active)
    );

    always #5 clk = ~clk;

    // Reference model: each lane tracks cycles of override left (-1 = sticky)
    logic [CW-1:0] m_shadow = '0;
    logic          m_dout = 1'b0;
    int            m_mode[NS];
    int            m_tsel[NS];
    int            m_hold[NS];
    int            m_rem[NS];

    int n_checks = 0;
    int n_fail = 0;
    logic [2*NS:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        if (!rst_n) begin
            m_shadow = '0;
            m_dout   = 1'b0;
            for (int i = 0; i < NS; i++) begin
                m_mode[i] = 0; m_tsel[i] = 0; m_hold[i] = 0; m_rem[i] = 0;
            end
            return;
        end
        for (int i = 0; i < NS; i++) begin
            if (cfg_commit) m_rem[i] = 0;
            else if (m_mode[i] != 0 && m_tsel[i] < NT && trig_in[m_tsel[i]])
                m_rem[i] = (m_hold[i] == 255) ? -1 : m_hold[i] + 1;
            else if (m_rem[i] > 0) m_rem[i] = m_rem[i] - 1;
        end
        if (cfg_commit) begin
            for (int i = 0; i < NS; i++) begin
                m_mode[i] = int'(m_shadow[i*FW +: 2]);
                m_tsel[i] = int'(m_shadow[i*FW+2 +: TW]);
                m_hold[i] = int'(m_shadow[i*FW+2+TW +: HW]);
            end
        end
        if (cfg_shift) begin
`ifdef PATCH_CTRL_READBACK_EN
            m_dout = m_shadow[0];
`endif
            m_shadow = {cfg_bit, m_shadow[CW-1:1]};
        end
    endfunction

    function automatic logic [2*NS:0] expect_now();
        logic [NS-1:0] so, ov;
        for (int i = 0; i < NS; i++) begin
            if (!rst_n || m_rem[i] == 0) begin
                so[i] = sig_in[i]; ov[i] = 1'b0;
            end else begin
                ov[i] = 1'b1;
                case (m_mode[i])
                    1:       so[i] = 1'b0;
                    2:       so[i] = 1'b1;
                    3:       so[i] = ~sig_in[i];
                    default: so[i] = sig_in[i];
                endcase
            end
        end
        return {so, ov, rst_n ? m_dout : 1'b0};
    endfunction

    task automatic drive(input logic [NT-1:0] t, input logic [NS-1:0] s,
                         input logic sh, input logic b, input logic cm, input logic r = 1'b1);
        @(posedge clk);
        model_step();
        #1;
        rst_n = r; trig_in = t; sig_in = s; cfg_shift = sh; cfg_bit = b; cfg_commit = cm;
        exp_q.push_back(expect_now());
    endtask

    function automatic logic [FW-1:0] mk_frame(input logic [1:0] mode, input logic [TW-1:0] tsel,
                                               input logic [HW-1:0] hold);
        return {hold, tsel, mode};
    endfunction

    task automatic load(input logic [CW-1:0] img, input logic do_commit);
        for (int b = 0; b < CW; b++) drive('0, NS'($urandom), 1'b1, img[b], 1'b0);
        if (do_commit) drive('0, NS'($urandom), 1'b0, 1'b0, 1'b1);
    endtask

    function automatic logic [NT-1:0] rnd_trig();
        logic [NT-1:0] t;
        for (int k = 0; k < NT; k++) t[k] = ($urandom % 5 == 0);
        return t;
    endfunction

    // Monitor: compares every cycle's outputs against the queued expectation
    initial begin : monitor
        logic [2*NS:0] e;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sig_out", 32'(sig_out), 32'(e[2*NS:NS+1]));
                check("ovr_active", 32'(ovr_active), 32'(e[NS:1]));
                check("cfg_dout", 32'(cfg_dout), 32'(e[0]));
            end
        end
    end

    initial begin : stimulus
        logic [CW-1:0] img;
        #2;
        check("reset sig_out", 32'(sig_out), 32'h0000000a);
        check("reset ovr_active", 32'(ovr_active), 32'h0);
        check("reset cfg_dout", 32'(cfg_dout), 32'h0);

        for (int c = 0; c < 4; c++) drive('1, (c % 2) ? 4'b0101 : 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) drive('1, (c % 2) ? 4'b0101 : 4'b1010, 1'b0, 1'b0, 1'b0);

        // Lane 0: force1, tsel 2, hold 3, single-cycle trigger
        img = '0; img[0*FW +: FW] = mk_frame(2'b10, 2'd2, 8'd3);
        load(img, 1'b1);
        drive(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) drive('0, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Lane 1: invert, tsel 1, hold 5, trigger held 3 cycles
        img = '0; img[1*FW +: FW] = mk_frame(2'b11, 2'd1, 8'd5);
        load(img, 1'b1);
        for (int c = 0; c < 3; c++) drive(4'b0010, NS'($urandom), 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 12; c++) drive('0, NS'($urandom), 1'b0, 1'b0, 1'b0);

        // Lane 2: sticky force0, then released by an all-pass commit
        img = '0; img[2*FW +: FW] = mk_frame(2'b01, 2'd3, 8'hFF);
        load(img, 1'b1);
        drive(4'b1000, 4'b1111, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 100; c++) drive('0, NS'($urandom), 1'b0, 1'b0, 1'b0);
        load('0, 1'b1);
        for (int c = 0; c < 3; c++) drive('0, 4'b1111, 1'b0, 1'b0, 1'b0);

        // Shift and commit together: commit must see the pre-shift image
        img = '0;
        for (int i = 0; i < NS; i++) img[i*FW +: FW] = mk_frame(2'b10, 2'd0, 8'd2);
        load(img, 1'b0);
        drive('0, 4'b0000, 1'b1, 1'b1, 1'b1);
        drive('1, 4'b0000, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) drive('0, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset during a sticky force1 override
        img = '0; img[0*FW +: FW] = mk_frame(2'b10, 2'd0, 8'hFF);
        load(img, 1'b1);
        drive(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) drive('0, 4'b0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        model_step();
        #1;
        rst_n = 1'b0;
        #1;
        check("async reset sig_out", 32'(sig_out), 32'h0);
        check("async reset ovr_active", 32'(ovr_active), 32'h0);
        exp_q.push_back(expect_now());
        drive('0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
        drive('0, 4'b0110, 1'b0, 1'b0, 1'b0);

        // Randomized images, triggers, partial shifts and stray commits
        for (int it = 0; it < 6; it++) begin
            img = '0;
            for (int i = 0; i < NS; i++)
                img[i*FW +: FW] = mk_frame(2'($urandom), TW'($urandom),
                                           ($urandom % 8 == 0) ? 8'hFF : HW'($urandom % 7));
            load(img, 1'b1);
            for (int c = 0; c < 120; c++)
                drive(rnd_trig(), NS'($urandom), ($urandom % 6 == 0), 1'($urandom),
                      ($urandom % 50 == 0));
        end

        for (int c = 0; c < 3; c++) drive('0, NS'($urandom), 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #5;
        check("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
